// File: rtl/ascon_io_pkg.sv
// Shared constants and types for the ASCON PS readback path.
//  - Default widths and word counts for the result reader.
//  - FSM state encoding.
//  - Status word layout and a helper that builds the word.
// Build option: ASCON_STATUS_WORD_EN appends a status word to every frame.
package ascon_io_pkg;

   localparam int unsigned DEF_CT_W   = 384;
   localparam int unsigned DEF_PT_W   = 256;
   localparam int unsigned DEF_WORD_W = 32;

   localparam int unsigned CT_WORDS = DEF_CT_W / DEF_WORD_W;
   localparam int unsigned PT_WORDS = DEF_PT_W / DEF_WORD_W;
`ifdef ASCON_STATUS_WORD_EN
   localparam int unsigned STATUS_WORDS = 1;
`else
   localparam int unsigned STATUS_WORDS = 0;
`endif
   localparam int unsigned NW    = CT_WORDS + PT_WORDS + STATUS_WORDS;
   localparam int unsigned IDX_W = $clog2(NW + 1);

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   // Status word layout: bit 31 auth_fail, bit 30 overrun, [15:0] word count.
   localparam int unsigned STAT_AUTH_BIT = 31;
   localparam int unsigned STAT_OVR_BIT  = 30;
   localparam int unsigned STAT_CNT_LSB  = 0;
   localparam int unsigned STAT_CNT_W    = 16;

   function automatic logic [31:0] status_word(input logic        auth,
                                               input logic        ovr,
                                               input logic [15:0] cnt);
      logic [31:0] w;
      w = '0;
      w[STAT_AUTH_BIT] = auth;
      w[STAT_OVR_BIT]  = ovr;
      w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/ascon_word_shifter.sv
// Loadable left shift register holding the result snapshot.
//  clk, rst    : clock, synchronous active-high reset (clears the register)
//  load        : capture load_data (has priority over shift)
//  load_data   : snapshot input, WIDTH bits
//  shift       : shift left by WORD_W bits, zero fill
//  msw         : most-significant WORD_W bits of the register
module ascon_word_shifter #(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_data,
   input  logic              shift,
   output logic [WORD_W-1:0] msw
);

   logic [WIDTH-1:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = load_data;
      end else if (shift) begin
         shreg_d = {shreg_q[WIDTH-WORD_W-1:0], {WORD_W{1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msw = shreg_q[WIDTH-1 -: WORD_W];

endmodule

// File: rtl/ascon_result_reader.sv
// PS readback of the ASCON PL core results.
// Snapshots ciphertext+tag and plaintext on cap_req (IDLE only), then streams
// the snapshot MSW first as WORD_W-bit words over a valid/ready handshake.
//  clk, rst   : clock, synchronous active-high reset
//  cap_req    : capture strobe
//  ct_in      : ciphertext+tag, CT_W bits
//  pt_in      : plaintext, PT_W bits (all-ones means tag mismatch)
//  rd_data    : current word (0 when not valid)
//  rd_valid   : rd_data valid
//  rd_ready   : consumer accepts word when rd_valid & rd_ready
//  rd_last    : final word of the frame
//  busy       : not IDLE
//  done       : one-cycle pulse after the final word is accepted
//  auth_fail  : plaintext was all-ones at the last capture
//  overrun    : sticky, cap_req seen while busy (cleared by a capture)
// Build option: ASCON_STATUS_WORD_EN appends the word
//  {auth_fail, overrun, 14'b0, 16'(NW)} after the plaintext words.
module ascon_result_reader
   import ascon_io_pkg::*;
#(
   parameter int unsigned CT_W   = DEF_CT_W,
   parameter int unsigned PT_W   = DEF_PT_W,
   parameter int unsigned WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_req,
   input  logic [CT_W-1:0]   ct_in,
   input  logic [PT_W-1:0]   pt_in,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last,
   output logic              busy,
   output logic              done,
   output logic              auth_fail,
   output logic              overrun
);

`ifdef ASCON_STATUS_WORD_EN
   localparam int unsigned NW_L = CT_W/WORD_W + PT_W/WORD_W + 1;
`else
   localparam int unsigned NW_L = CT_W/WORD_W + PT_W/WORD_W;
`endif
   localparam int unsigned IDX_L = $clog2(NW_L + 1);
   localparam logic [IDX_L-1:0] LAST_IDX = IDX_L'(NW_L - 1);

   state_t           state_q, state_d;
   logic [IDX_L-1:0] idx_q, idx_d;
   logic             auth_q, auth_d;
   logic             ovr_q, ovr_d;
   logic             load, shift;
   logic [WORD_W-1:0] msw;

   ascon_word_shifter #(
      .WIDTH  (CT_W + PT_W),
      .WORD_W (WORD_W)
   ) u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data ({ct_in, pt_in}),
      .shift     (shift),
      .msw       (msw)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      auth_d  = auth_q;
      ovr_d   = ovr_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cap_req) begin
               load    = 1'b1;
               idx_d   = '0;
               auth_d  = &pt_in;
               ovr_d   = 1'b0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (cap_req) begin
               ovr_d = 1'b1;
            end
            if (rd_ready) begin
               shift = 1'b1;
               idx_d = idx_q + IDX_L'(1);
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (cap_req) begin
               ovr_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         auth_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         auth_q  <= auth_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      rd_valid = (state_q == SEND);
      rd_last  = rd_valid && (idx_q == LAST_IDX);
      rd_data  = '0;
      if (rd_valid) begin
`ifdef ASCON_STATUS_WORD_EN
         // Shadow is exhausted by the status slot; overrun is the live flag.
         if (idx_q == LAST_IDX) begin
            rd_data = WORD_W'(status_word(auth_q, ovr_q, 16'(NW_L)));
         end else begin
            rd_data = msw;
         end
`else
         rd_data = msw;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign auth_fail = auth_q;
   assign overrun   = ovr_q;

endmodule
